// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM path: rebuilds channel words a..d from a slotted stream.
// Define TDM_PARITY_EN to add a fifth, even-parity slot checked before each frame is released.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [2:0]       slot,
   output logic             locked,
   output logic             frame_valid,
   output logic             sync_err,
   output logic             parity_err
);

`ifdef TDM_PARITY_EN
   localparam int unsigned NumShadow = 4;
   localparam logic [2:0]  LastSlot  = 3'd4;
`else
   localparam int unsigned NumShadow = 3;
   localparam logic [2:0]  LastSlot  = 3'd3;
`endif

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [2:0]       slot_q, slot_d;
   logic [WIDTH-1:0] shadow_q [NumShadow];
   logic [WIDTH-1:0] shadow_d [NumShadow];
   logic [WIDTH-1:0] out_q [4];
   logic [WIDTH-1:0] out_d [4];
   logic             fv_q, fv_d;
   logic             se_q, se_d;
   logic             pe_q, pe_d;

`ifdef TDM_PARITY_EN
   logic parity_ok;
   // Even parity over every bit of slots 0..3; only bit 0 of the parity slot is meaningful.
   assign parity_ok = (^{shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3]}) == din[0];
`endif

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      fv_d     = 1'b0;
      se_d     = 1'b0;
      pe_d     = 1'b0;
      if (en) begin
         case (state_q)
            StIdle: begin
               if (sync) begin
                  shadow_d[0] = din;
                  slot_d      = 3'd1;
                  state_d     = StRun;
               end
            end
            StRun: begin
               if (sync) begin
                  // Sync anywhere but slot 0 abandons the partial frame and restarts it.
                  se_d        = (slot_q != 3'd0);
                  shadow_d[0] = din;
                  slot_d      = 3'd1;
               end else if (slot_q == 3'd0) begin
                  se_d    = 1'b1;
                  state_d = StIdle;
               end else if (slot_q == LastSlot) begin
                  slot_d = 3'd0;
`ifdef TDM_PARITY_EN
                  if (parity_ok) begin
                     out_d = shadow_d;
                     fv_d  = 1'b1;
                  end else begin
                     pe_d = 1'b1;
                  end
`else
                  out_d[0] = shadow_q[0];
                  out_d[1] = shadow_q[1];
                  out_d[2] = shadow_q[2];
                  out_d[3] = din;
                  fv_d     = 1'b1;
`endif
               end else begin
                  shadow_d[slot_q[1:0]] = din;
                  slot_d                = slot_q + 3'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         slot_q   <= 3'd0;
         shadow_q <= '{default: '0};
         out_q    <= '{default: '0};
         fv_q     <= 1'b0;
         se_q     <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         fv_q     <= fv_d;
         se_q     <= se_d;
         pe_q     <= pe_d;
      end
   end

   assign a           = out_q[0];
   assign b           = out_q[1];
   assign c           = out_q[2];
   assign d           = out_q[3];
   assign slot        = slot_q;
   assign locked      = (state_q == StRun);
   assign frame_valid = fv_q;
   assign sync_err    = se_q;
`ifdef TDM_PARITY_EN
   assign parity_err  = pe_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (WIDTH=1, default 4-slot build): hand-built vector table followed by
// random traffic compared against a frame-queue model.
module tb_tdm_demux4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [0:0] din = '0;
   logic       en = 1'b0;
   logic       sync = 1'b0;
   logic [0:0] a, b, c, d;
   logic [2:0] slot;
   logic       locked, frame_valid, sync_err, parity_err;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   tdm_demux4 #(.WIDTH(1)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .din        (din),
      .en         (en),
      .sync       (sync),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .slot       (slot),
      .locked     (locked),
      .frame_valid(frame_valid),
      .sync_err   (sync_err),
      .parity_err (parity_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       sync;
      logic       din;
      logic [3:0] abcd;
      logic [2:0] slot;
      logic       locked;
      logic       fv;
      logic       se;
   } vec_t;

   vec_t vecs [$];

   // Model: a frame is just the list of words received since the last accepted sync.
   logic m_locked;
   logic m_frame [$];
   logic m_out [4];
   logic m_fv, m_se;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_edge(input logic r, input logic e, input logic s, input logic dv);
      m_fv = 1'b0;
      m_se = 1'b0;
      if (!r) begin
         m_locked = 1'b0;
         m_frame.delete();
         for (int i = 0; i < 4; i++) m_out[i] = 1'b0;
      end else if (e) begin
         if (s) begin
            if (m_locked && m_frame.size() != 0) m_se = 1'b1;
            m_locked = 1'b1;
            m_frame.delete();
            m_frame.push_back(dv);
         end else if (m_locked) begin
            if (m_frame.size() == 0) begin
               m_se     = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_frame.push_back(dv);
               if (m_frame.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                  m_fv = 1'b1;
                  m_frame.delete();
               end
            end
         end
      end
   endtask

   task automatic apply(input logic r, input logic e, input logic s, input logic dv);
      reset_n = r;
      en      = e;
      sync    = s;
      din     = dv;
      @(posedge clock);
      model_edge(r, e, s, dv);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic s, input logic dv,
                               input logic [3:0] abcd, input int unsigned sl, input logic lk,
                               input logic fv, input logic se);
      vec_t v;
      v.rst_n = r; v.en = e; v.sync = s; v.din = dv; v.abcd = abcd;
      v.slot = 3'(sl); v.locked = lk; v.fv = fv; v.se = se;
      return v;
   endfunction

   initial begin
      // frame 1,0,0,1
      vecs.push_back(mk(1, 1, 1, 1, 4'b0000, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 3, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b1001, 0, 1, 1, 0));
      // frame 0,1,1,0 with a 3-cycle en gap between slots 1 and 2
      vecs.push_back(mk(1, 1, 1, 0, 4'b1001, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b1001, 2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 4'b1001, 2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 4'b1001, 2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 4'b1001, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b1001, 3, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b0110, 0, 1, 1, 0));
      // early sync at slot 2: that word becomes a, frame finishes 3 slots later
      vecs.push_back(mk(1, 1, 1, 1, 4'b0110, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0110, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 4'b0110, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0110, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0110, 3, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0111, 0, 1, 1, 0));
      // missing sync at slot 0 -> unlock; en without sync ignored
      vecs.push_back(mk(1, 1, 0, 1, 4'b0111, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0111, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 4'b0111, 0, 0, 0, 0));
      // relock, then reset after slots 0..1, then a clean frame 1,1,0,1
      vecs.push_back(mk(1, 1, 1, 0, 4'b0111, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b0111, 2, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 4'b0000, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b0000, 2, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 3, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 4'b1101, 0, 1, 1, 0));

      // Reset state
      apply(0, 0, 0, 0);
      apply(0, 1, 1, 1);
      check("rst_abcd", {a, b, c, d}, 4'b0000);
      check("rst_slot", slot, 0);
      check("rst_locked", locked, 0);
      check("rst_fv", frame_valid, 0);
      check("rst_se", sync_err, 0);
      check("rst_pe", parity_err, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst_n, vecs[i].en, vecs[i].sync, vecs[i].din);
         check($sformatf("vec%0d_abcd", i), {a, b, c, d}, vecs[i].abcd);
         check($sformatf("vec%0d_slot", i), slot, vecs[i].slot);
         check($sformatf("vec%0d_locked", i), locked, vecs[i].locked);
         check($sformatf("vec%0d_fv", i), frame_valid, vecs[i].fv);
         check($sformatf("vec%0d_se", i), sync_err, vecs[i].se);
      end

      // Random traffic against the queue model
      apply(0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         logic r, e, s, dv;
         r  = ($urandom_range(0, 199) != 0);
         e  = ($urandom_range(0, 9) < 7);
         s  = ($urandom_range(0, 9) < 2);
         dv = 1'($urandom);
         apply(r, e, s, dv);
         check("rnd_abcd", {a, b, c, d}, {m_out[0], m_out[1], m_out[2], m_out[3]});
         check("rnd_slot", slot, m_locked ? m_frame.size() : 0);
         check("rnd_locked", locked, m_locked);
         check("rnd_fv", frame_valid, m_fv);
         check("rnd_se", sync_err, m_se);
         check("rnd_pe", parity_err, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
